result_wb_control: RTL

Writeback controller for the output buffer (ob). On a one-cycle `conf` it issues a single DDR write command, then reads `line_num` consecutive lines from the banked output buffer and pushes them, in address order, into the DDR write FIFO. A small internal skid FIFO absorbs buffer read latency, so FIFO backpressure never loses or duplicates a line. It is the store-side counterpart of the bias/weight load controllers and sits between the output buffer banks and the DDR write-FIFO port.

---
 rtl/result_wb_control_pkg.sv | 26 ++
 rtl/wb_skid_fifo.sv | 61 ++++++
 rtl/result_wb_control.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/result_wb_control_pkg.sv
// Shared types, line-geometry constants and helpers for the result writeback controller.
package result_wb_control_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } wb_state_e;

  localparam int unsigned DEF_X_PE       = 16;
  localparam int unsigned DEF_DATA_LEN   = 64;
  localparam int unsigned DEF_BUFFER_NUM = 8 * DEF_X_PE / DEF_DATA_LEN;
  localparam int unsigned LINE_W         = DEF_DATA_LEN * DEF_BUFFER_NUM;
  localparam int unsigned LINE_BYTES     = LINE_W / 8;

  // Ceiling log2; clogb2(1) = 0.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Small synchronous first-word-fall-through FIFO that absorbs buffer read latency.
module wb_skid_fifo
  import result_wb_control_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = clogb2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? clogb2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Push/pop qualification, pointer wrap and occupancy update.
  always_comb begin
    do_pop   = pop_i && (cnt_q != '0);
    do_push  = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CNT_W'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/result_wb_control.sv
// Output-buffer writeback controller: one DDR write command per job, then
// line_num buffer reads streamed in order into the DDR write FIFO via a skid FIFO.
module result_wb_control
  import result_wb_control_pkg::*;
#(
  parameter int unsigned X_PE         = DEF_X_PE,
  parameter int unsigned DDR_ADDR_LEN = 32,
  parameter int unsigned ADDR_LEN     = 16,
  parameter int unsigned DATA_LEN     = DEF_DATA_LEN,
  parameter int unsigned BUFFER_NUM   = 8 * X_PE / DATA_LEN,
  parameter int unsigned SINGLE_LEN   = 24,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned SKID_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           conf,
  input  logic [SINGLE_LEN-1:0]          line_num,
  input  logic [DDR_ADDR_LEN-1:0]        ddr_st_addr,
  input  logic [ADDR_LEN-1:0]            ob_st_addr,
  output logic [DDR_ADDR_LEN-1:0]        ddr_st_addr_out,
  output logic [SINGLE_LEN-1:0]          ddr_len,
  output logic                           ddr_conf,
  output logic [ADDR_LEN-1:0]            ob_addr,
  output logic                           ob_rd_en,
  input  logic [DATA_LEN*BUFFER_NUM-1:0] ob_data,
  input  logic                           ddr_fifo_full,
  output logic                           ddr_fifo_wr,
  output logic [DATA_LEN*BUFFER_NUM-1:0] ddr_fifo_data,
  output logic                           idle,
  output logic                           done
);

  localparam int unsigned LW    = DATA_LEN * BUFFER_NUM;
  localparam int unsigned CNT_W = clogb2(SKID_DEPTH + 1);
  localparam int unsigned OCC_W = clogb2(SKID_DEPTH + RD_LAT + 1);
  localparam logic [SINGLE_LEN-1:0] BYTES_PER_LINE = SINGLE_LEN'(LW / 8);

  wb_state_e               state_q, state_d;
  logic [SINGLE_LEN-1:0]   len_q, len_d;
  logic [SINGLE_LEN-1:0]   rd_cnt_q, rd_cnt_d;
  logic [SINGLE_LEN-1:0]   wr_cnt_q, wr_cnt_d;
  logic [SINGLE_LEN-1:0]   ddr_len_q, ddr_len_d;
  logic [ADDR_LEN-1:0]     base_q, base_d;
  logic [DDR_ADDR_LEN-1:0] daddr_q, daddr_d;
  logic                    ddr_conf_q, ddr_conf_d;
  logic                    done_q, done_d;
  logic [RD_LAT-1:0]       vld_q, vld_d;

  logic                    rd_en, wr_en;
  logic                    skid_empty;
  logic [CNT_W-1:0]        skid_cnt;
  logic [OCC_W-1:0]        occ;
  logic [LW-1:0]           skid_head;

  wb_skid_fifo #(
    .WIDTH (LW),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (vld_q[RD_LAT-1]),
    .data_i  (ob_data),
    .pop_i   (wr_en),
    .data_o  (skid_head),
    .empty_o (skid_empty),
    .count_o (skid_cnt)
  );

  // Lines already buffered plus reads still in flight; reads are only issued
  // while this stays below the skid depth, so returning data always has room.
  always_comb begin
    occ = OCC_W'(skid_cnt);
    for (int unsigned i = 0; i < RD_LAT; i++) occ = occ + OCC_W'(vld_q[i]);
  end

  // Next-state logic for the IDLE/RUN/DRAIN sequencer, counters and strobes.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    base_d     = base_q;
    daddr_d    = daddr_q;
    ddr_len_d  = ddr_len_q;
    rd_cnt_d   = rd_cnt_q;
    ddr_conf_d = 1'b0;
    done_d     = 1'b0;
    rd_en      = 1'b0;
    wr_en      = !skid_empty && !ddr_fifo_full;
    wr_cnt_d   = wr_en ? wr_cnt_q + SINGLE_LEN'(1) : wr_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (conf) begin
          if (line_num != '0) begin
            state_d    = ST_RUN;
            len_d      = line_num;
            base_d     = ob_st_addr;
            daddr_d    = ddr_st_addr;
            ddr_len_d  = line_num * BYTES_PER_LINE;
            rd_cnt_d   = '0;
            wr_cnt_d   = '0;
            ddr_conf_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if ((rd_cnt_q < len_q) && (occ < OCC_W'(SKID_DEPTH))) begin
          rd_en    = 1'b1;
          rd_cnt_d = rd_cnt_q + SINGLE_LEN'(1);
          if (rd_cnt_d == len_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wr_cnt_d == len_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    vld_d[0] = rd_en;
    for (int unsigned i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
  end

  // State, counter and in-flight pipe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      base_q     <= '0;
      daddr_q    <= '0;
      ddr_len_q  <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      ddr_conf_q <= 1'b0;
      done_q     <= 1'b0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      base_q     <= base_d;
      daddr_q    <= daddr_d;
      ddr_len_q  <= ddr_len_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      ddr_conf_q <= ddr_conf_d;
      done_q     <= done_d;
      vld_q      <= vld_d;
    end
  end

  assign ob_addr         = base_q + rd_cnt_q[ADDR_LEN-1:0];
  assign ob_rd_en        = rd_en;
  assign ddr_fifo_wr     = wr_en;
  assign ddr_fifo_data   = skid_empty ? '0 : skid_head;
  assign ddr_st_addr_out = daddr_q;
  assign ddr_len         = ddr_len_q;
  assign ddr_conf        = ddr_conf_q;
  assign done            = done_q;
  assign idle            = (state_q == ST_IDLE);

endmodule
